// File: rtl/i2c_cfg_sequencer.sv
// Table-driven codec configuration sequencer: fetches {op, addr, data} entries and issues
// Avalon-MM writes, verified writes with retries, and tick delays.
module i2c_cfg_sequencer #(
   parameter int TABLE_DEPTH       = 64,
   parameter int MAX_RETRIES       = 3,
   parameter int DELAY_TICK_CYCLES = 25000,
   parameter int TIMEOUT_CYCLES    = 2000000,
   parameter bit AUTO_START        = 1'b1,
   localparam int AW = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1
) (
   input  logic          clk_i,
   input  logic          srst_n_i,
   input  logic          start_i,
   output logic [AW-1:0] tbl_addr_o,
   input  logic [33:0]   tbl_data_i,
   output logic [15:0]   amm_address_o,
   output logic [15:0]   amm_writedata_o,
   output logic          amm_write_o,
   output logic          amm_read_o,
   input  logic [15:0]   amm_readdata_i,
   input  logic          amm_readdatavalid_i,
   input  logic          amm_waitrequest_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          error_o,
   output logic [AW-1:0] err_index_o
);

   // state      | meaning
   // IDLE       | waiting for start_i or the post-reset auto start
   // FETCH      | table address driven
   // FETCH_WAIT | table read latency cycle
   // DECODE     | entry registered, branch on op
   // WR         | Avalon write outstanding
   // RD         | Avalon read outstanding / waiting for read data
   // CHECK      | compare readback with written data
   // DELAY      | counting tick_count * DELAY_TICK_CYCLES
   // DONE       | table finished cleanly
   // FAIL       | retries exhausted or bus timeout

   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam int DW = (DELAY_TICK_CYCLES > 1) ? $clog2(DELAY_TICK_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [AW-1:0] LAST_IDX  = AW'(TABLE_DEPTH - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
   localparam logic [DW-1:0] TICK_LOAD = DW'(DELAY_TICK_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] OP_END    = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_VERIFY = 2'b10;

   typedef enum logic [3:0] {
      IDLE, FETCH, FETCH_WAIT, DECODE, WR, RD, CHECK, DELAY, DONE, FAIL
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   index_q, index_d;
   logic [33:0]     entry_q;
   logic [RW-1:0]   retry_q;
   logic [15:0]     tick_q;
   logic [DW-1:0]   cyc_q;
   logic [TW-1:0]   tmo_q;
   logic            rd_acc_q;
   logic [15:0]     rd_data_q;
   logic            done_q, error_q;
   logic [AW-1:0]   err_index_q;
   logic            auto_pend_q;
   logic            go, adv, retry_inc, rd_bad;

   wire [1:0]  op       = entry_q[33:32];
   wire [15:0] reg_data = entry_q[15:0];

   assign go     = start_i | auto_pend_q;
   assign rd_bad = (rd_data_q != reg_data) || (rd_data_q == 16'hdead);

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      adv       = 1'b0;
      retry_inc = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (go) begin
               state_d = FETCH;
               index_d = '0;
            end
         end
         FETCH:      state_d = FETCH_WAIT;
         FETCH_WAIT: state_d = DECODE;
         DECODE: begin
            if (op == OP_END)                          state_d = DONE;
            else if (op == OP_WRITE || op == OP_VERIFY) state_d = WR;
            else if (reg_data == 16'd0)                 adv     = 1'b1;
            else                                        state_d = DELAY;
         end
         WR: begin
            if (!amm_waitrequest_i) begin
               if (op == OP_VERIFY) state_d = RD;
               else                 adv     = 1'b1;
            end else if (tmo_q == '0) begin
               state_d = FAIL;
            end
         end
         RD: begin
            if (amm_readdatavalid_i)                          state_d = CHECK;
            else if (!rd_acc_q && amm_waitrequest_i && tmo_q == '0) state_d = FAIL;
         end
         CHECK: begin
            if (!rd_bad)                  adv     = 1'b1;
            else if (retry_q == RETRY_MAX) state_d = FAIL;
            else begin
               retry_inc = 1'b1;
               state_d   = WR;
            end
         end
         DELAY: begin
            if (cyc_q == '0 && tick_q == 16'd0) adv = 1'b1;
         end
         DONE:    state_d = IDLE;
         FAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // The last entry finishes the table instead of wrapping to entry 0.
      if (adv) begin
         if (index_q == LAST_IDX) state_d = DONE;
         else begin
            state_d = FETCH;
            index_d = index_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state_q     <= IDLE;
         index_q     <= '0;
         entry_q     <= '0;
         retry_q     <= '0;
         tick_q      <= '0;
         cyc_q       <= '0;
         tmo_q       <= '0;
         rd_acc_q    <= 1'b0;
         rd_data_q   <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_index_q <= '0;
         auto_pend_q <= AUTO_START;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         if (state_q == IDLE) auto_pend_q <= 1'b0;
         if (state_q == IDLE && go) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
         end
         if (state_q == FETCH_WAIT) entry_q <= tbl_data_i;
         if (state_q == DECODE) begin
            retry_q <= '0;
            tick_q  <= reg_data - 16'd1;
            cyc_q   <= TICK_LOAD;
         end else if (state_q == DELAY) begin
            if (cyc_q == '0) begin
               cyc_q  <= TICK_LOAD;
               tick_q <= tick_q - 16'd1;
            end else begin
               cyc_q <= cyc_q - 1'b1;
            end
         end
         if (retry_inc) retry_q <= retry_q + 1'b1;
         // Each new WR/RD visit gets a fresh timeout budget.
         if (state_d != state_q)             tmo_q <= TMO_LOAD;
         else if (amm_write_o || amm_read_o) tmo_q <= tmo_q - 1'b1;
         if (state_q == RD && amm_read_o && !amm_waitrequest_i) rd_acc_q <= 1'b1;
         else if (state_q != RD)                                  rd_acc_q <= 1'b0;
         if (state_q == RD && amm_readdatavalid_i) rd_data_q <= amm_readdata_i;
         if (state_q == DONE) begin
            done_q  <= 1'b1;
            error_q <= 1'b0;
         end
         if (state_q == FAIL) begin
            error_q     <= 1'b1;
            done_q      <= 1'b0;
            err_index_q <= index_q;
         end
      end
   end

   assign tbl_addr_o      = index_q;
   assign amm_address_o   = entry_q[31:16];
   assign amm_writedata_o = entry_q[15:0];
   assign amm_write_o     = (state_q == WR);
   assign amm_read_o      = (state_q == RD) && !rd_acc_q;
   assign busy_o          = !(state_q == IDLE || state_q == DONE || state_q == FAIL);
   assign done_o          = done_q;
   assign error_o         = error_q;
   assign err_index_o     = err_index_q;

endmodule
